// File: rtl/instr_buffer.sv
// Circular instruction buffer between fetch and dispatch: all-or-nothing group
// enqueue, in-order window of the oldest entries, and partial per-cycle dequeue.
`ifndef N
`define N 3
`endif

module instr_buffer #(
    parameter int N     = `N,
    parameter int IB_SZ = 8,
    parameter int FP_W  = 32,
    localparam int CW   = $clog2(IB_SZ + 1),
    localparam int DW   = $clog2(N + 1),
    localparam int PW   = (IB_SZ > 1) ? $clog2(IB_SZ) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [N-1:0][FP_W-1:0]   fetch_packets,
    input  logic [N-1:0]             fetch_valid,
    output logic                     fetch_accept,
    output logic [CW-1:0]            ib_free_slots,
    input  logic [DW-1:0]            dispatch_count,
    output logic [N-1:0][FP_W-1:0]   dispatch_window,
    output logic [DW-1:0]            window_valid_count
);

    logic [FP_W-1:0] mem_q [IB_SZ];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   enq_n_s;
    logic [CW-1:0]   free_s;
    logic [DW-1:0]   wvc_s;
    logic [DW-1:0]   deq_n_s;
    logic            accept_s;

    // Depth need not be a power of two, so wrap with one compare-and-subtract;
    // ptr < IB_SZ and inc <= IB_SZ keep the sum below 2*IB_SZ.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr,
                                               input logic [PW:0]   inc);
        logic [PW:0] sum;
        sum = {1'b0, ptr} + inc;
        return (sum >= (PW+1)'(IB_SZ)) ? PW'(sum - (PW+1)'(IB_SZ)) : sum[PW-1:0];
    endfunction

    // Occupancy bookkeeping: accept decision, dequeue clamp and next pointers.
    always_comb begin
        enq_n_s = '0;
        for (int k = 0; k < N; k++) begin
            enq_n_s = enq_n_s + CW'(fetch_valid[k]);
        end
        free_s   = CW'(IB_SZ) - count_q;
        accept_s = (enq_n_s <= free_s) && !flush;
        wvc_s    = (count_q >= CW'(N)) ? DW'(N) : DW'(count_q);
        deq_n_s  = (dispatch_count < wvc_s) ? dispatch_count : wvc_s;
        head_d   = wrap_add(head_q, (PW+1)'(deq_n_s));
        tail_d   = accept_s ? wrap_add(tail_q, (PW+1)'(enq_n_s)) : tail_q;
        count_d  = count_q + (accept_s ? enq_n_s : '0) - CW'(deq_n_s);
    end

    // Dispatch window straight from registered state; invalid lanes forced to zero.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            if (DW'(k) < wvc_s) begin
                dispatch_window[k] = mem_q[wrap_add(head_q, (PW+1)'(k))];
            end else begin
                dispatch_window[k] = '0;
            end
        end
    end

    assign fetch_accept       = accept_s;
    assign ib_free_slots      = free_s;
    assign window_valid_count = wvc_s;

    // Pointer and count registers; flush empties the buffer at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; stale contents are never visible because the window masks them.
    always_ff @(posedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (accept_s && fetch_valid[k]) begin
                mem_q[wrap_add(tail_q, (PW+1)'(k))] <= fetch_packets[k];
            end
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the buffer contents.
module tb_instr_buffer;

    localparam int N     = 3;
    localparam int IB_SZ = 8;
    localparam int FP_W  = 32;
    localparam int CW    = $clog2(IB_SZ + 1);
    localparam int DW    = $clog2(N + 1);

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   flush;
    logic [N-1:0][FP_W-1:0] fetch_packets;
    logic [N-1:0]           fetch_valid;
    logic                   fetch_accept;
    logic [CW-1:0]          ib_free_slots;
    logic [DW-1:0]          dispatch_count;
    logic [N-1:0][FP_W-1:0] dispatch_window;
    logic [DW-1:0]          window_valid_count;

    int checks   = 0;
    int failures = 0;
    logic [FP_W-1:0] model_q[$];
    logic [31:0]     next_pc;
    logic            acc_s;
    logic [31:0]     saved_pc;

    instr_buffer #(.N(N), .IB_SZ(IB_SZ), .FP_W(FP_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .flush              (flush),
        .fetch_packets      (fetch_packets),
        .fetch_valid        (fetch_valid),
        .fetch_accept       (fetch_accept),
        .ib_free_slots      (ib_free_slots),
        .dispatch_count     (dispatch_count),
        .dispatch_window    (dispatch_window),
        .window_valid_count (window_valid_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic check_outputs(input string tag);
        int sz;
        int en;
        int wv;
        sz = model_q.size();
        en = 0;
        for (int k = 0; k < N; k++) en += int'(fetch_valid[k]);
        wv = (sz < N) ? sz : N;
        check_eq({tag, ".accept"}, 64'(fetch_accept), 64'((en <= IB_SZ - sz) && !flush));
        check_eq({tag, ".free"},   64'(ib_free_slots), 64'(IB_SZ - sz));
        check_eq({tag, ".wvc"},    64'(window_valid_count), 64'(wv));
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("%s.lane%0d", tag, k), 64'(dispatch_window[k]),
                     (k < wv) ? 64'(model_q[k]) : 64'd0);
        end
    endtask

    // One clock cycle: drive at negedge, check, advance the model, wait for posedge.
    task automatic step(input logic [N-1:0] fv, input logic [DW-1:0] dc,
                        input logic fl, input string tag, output logic acc);
        int en;
        int sz;
        int wv;
        int d;
        @(negedge clock);
        fetch_valid    = fv;
        dispatch_count = dc;
        flush          = fl;
        en = 0;
        for (int k = 0; k < N; k++) begin
            en += int'(fv[k]);
            fetch_packets[k] = fv[k] ? (next_pc + 32'(4 * k)) : $urandom;
        end
        #1;
        check_outputs(tag);
        sz  = model_q.size();
        wv  = (sz < N) ? sz : N;
        acc = (en <= IB_SZ - sz) && !fl;
        if (fl) begin
            model_q.delete();
        end else begin
            d = (int'(dc) < wv) ? int'(dc) : wv;
            repeat (d) void'(model_q.pop_front());
            if (acc) begin
                for (int k = 0; k < en; k++) model_q.push_back(next_pc + 32'(4 * k));
                next_pc = next_pc + 32'(4 * en);
            end
        end
        @(posedge clock);
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        fetch_valid    = '0;
        dispatch_count = '0;
        fetch_packets  = '0;
        next_pc        = 32'h0;
        #1;
        check_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Single enqueue after reset
        step(3'b111, 2'd0, 1'b0, "t1.enq", acc_s);
        step(3'b000, 2'd0, 1'b0, "t1.win", acc_s);
        #1;
        check_eq("t1.free5", 64'(ib_free_slots), 64'd5);
        check_eq("t1.lane2", 64'(dispatch_window[2]), 64'h8);

        // Fill to full
        step(3'b000, 2'd0, 1'b1, "t2.flush", acc_s);
        step(3'b111, 2'd0, 1'b0, "t2.g1", acc_s);
        step(3'b111, 2'd0, 1'b0, "t2.g2", acc_s);
        step(3'b111, 2'd0, 1'b0, "t2.g3rej", acc_s);
        step(3'b011, 2'd0, 1'b0, "t2.g4", acc_s);
        #1;
        check_eq("t2.full_free", 64'(ib_free_slots), 64'd0);

        // Simultaneous enqueue/dequeue at full
        step(3'b111, 2'd3, 1'b0, "t4.full", acc_s);
        step(3'b111, 2'd0, 1'b0, "t4.retry", acc_s);
        #1;
        check_eq("t4.free0", 64'(ib_free_slots), 64'd0);

        // Partial dispatch with wrap from head 0
        step(3'b000, 2'd0, 1'b1, "t3.flush", acc_s);
        step(3'b111, 2'd0, 1'b0, "t3.f1", acc_s);
        step(3'b111, 2'd0, 1'b0, "t3.f2", acc_s);
        step(3'b011, 2'd0, 1'b0, "t3.f3", acc_s);
        for (int i = 0; i < 20; i++) begin
            step(3'b011, 2'd2, 1'b0, $sformatf("t3.c%0d", i), acc_s);
        end

        // Flush with concurrent fetch and dispatch
        step(3'b000, 2'd0, 1'b1, "t5.pre", acc_s);
        step(3'b111, 2'd0, 1'b0, "t5.f1", acc_s);
        step(3'b011, 2'd0, 1'b0, "t5.f2", acc_s);
        step(3'b111, 2'd1, 1'b1, "t5.flush", acc_s);
        #1;
        check_eq("t5.wvc0",  64'(window_valid_count), 64'd0);
        check_eq("t5.free8", 64'(ib_free_slots), 64'd8);
        check_eq("t5.win0",  64'(dispatch_window[0]), 64'd0);

        // Asynchronous reset mid-operation
        step(3'b111, 2'd0, 1'b0, "t6.f1", acc_s);
        step(3'b001, 2'd0, 1'b0, "t6.f2", acc_s);
        #2;
        fetch_valid = '0;
        reset = 1'b1;
        #1;
        check_eq("t6.async_wvc",  64'(window_valid_count), 64'd0);
        check_eq("t6.async_free", 64'(ib_free_slots), 64'd8);
        check_eq("t6.async_win",  64'(dispatch_window), 64'd0);
        model_q.delete();
        @(negedge clock);
        reset = 1'b0;
        saved_pc = next_pc;
        step(3'b001, 2'd0, 1'b0, "t6.enq", acc_s);
        #1;
        check_eq("t6.lane0", 64'(dispatch_window[0]), 64'(saved_pc));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int len;
            logic [N-1:0] fv;
            logic [DW-1:0] dc;
            logic fl;
            len = $urandom_range(0, N);
            fv  = N'((1 << len) - 1);
            dc  = DW'($urandom_range(0, N));
            fl  = ($urandom_range(0, 19) == 0);
            step(fv, dc, fl, $sformatf("rnd%0d", i), acc_s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
